// File: rtl/vector_memory_arbiter.sv
// Arbitrates the single-port vector data memory between the CPU M-stage and a host loader port.
// The CPU has priority; a starvation counter forces one host slot after STARVE_LIMIT blocked cycles.
module vector_memory_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 16,
    parameter int STARVE_LIMIT  = 4,
    parameter int COUNT_WIDTH   = 3
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_cpuRequest,
    input  logic                                i_cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0]            i_cpuAddress,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   i_cpuWriteData,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   o_cpuReadData,
    output logic                                o_cpuStall,
    input  logic                                i_hostValid,
    input  logic                                i_hostWrite,
    input  logic [ADDRESS_WIDTH-1:0]            i_hostAddress,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   i_hostWriteData,
    output logic                                o_hostReady,
    output logic                                o_hostReadValid,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   o_hostReadData,
    output logic                                o_memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0]            o_memAddress,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0]   o_memWriteData,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   i_memReadData
);

    localparam int WORD_W = DATA_WIDTH * VECTOR_SIZE;
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_NORMAL     = 1'b0,
        ST_FORCE_HOST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    state_t                 r_state;
    owner_t                 r_readOwner;
    logic [COUNT_WIDTH-1:0] r_starveCount;

    logic                   w_grantCpu;
    logic                   w_grantHost;
    logic [COUNT_WIDTH-1:0] w_starveInc;
    owner_t                 w_nextOwner;

    // Grants are suppressed entirely while reset is held so no stray write reaches memory.
    always_comb begin
        w_grantCpu  = 1'b0;
        w_grantHost = 1'b0;
        if (i_reset) begin
            if (r_state == ST_FORCE_HOST) begin
                w_grantHost = i_hostValid;
                w_grantCpu  = i_cpuRequest & ~i_hostValid;
            end else begin
                w_grantCpu  = i_cpuRequest;
                w_grantHost = i_hostValid & ~i_cpuRequest;
            end
        end
    end

    assign o_cpuStall  = i_cpuRequest & ~w_grantCpu & i_reset;
    assign o_hostReady = w_grantHost;

    always_comb begin
        o_memWriteEnable = 1'b0;
        o_memAddress     = '0;
        o_memWriteData   = '0;
        if (w_grantCpu) begin
            o_memWriteEnable = i_cpuWrite;
            o_memAddress     = i_cpuAddress;
            o_memWriteData   = i_cpuWriteData;
        end else if (w_grantHost) begin
            o_memWriteEnable = i_hostWrite;
            o_memAddress     = i_hostAddress;
            o_memWriteData   = i_hostWriteData;
        end
    end

    always_comb begin
        w_nextOwner = OWN_NONE;
        if (w_grantHost && !i_hostWrite)
            w_nextOwner = OWN_HOST;
        else if (w_grantCpu && !i_cpuWrite)
            w_nextOwner = OWN_CPU;
    end

    assign w_starveInc = (r_starveCount >= LIMIT) ? LIMIT : r_starveCount + 1'b1;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= ST_NORMAL;
            r_starveCount <= '0;
            r_readOwner   <= OWN_NONE;
        end else begin
            r_readOwner <= w_nextOwner;
            case (r_state)
                ST_NORMAL: begin
                    if (!i_hostValid || w_grantHost) begin
                        r_starveCount <= '0;
                    end else if (w_grantCpu) begin
                        r_starveCount <= w_starveInc;
                        if (w_starveInc == LIMIT)
                            r_state <= ST_FORCE_HOST;
                    end
                end
                ST_FORCE_HOST: begin
                    // One host transfer (or a withdrawn host request) ends the forced slot.
                    if (w_grantHost || !i_hostValid) begin
                        r_state       <= ST_NORMAL;
                        r_starveCount <= '0;
                    end
                end
                default: begin
                    r_state       <= ST_NORMAL;
                    r_starveCount <= '0;
                end
            endcase
        end
    end

    // Read data is shared; ownership only qualifies the host's valid pulse.
    assign o_hostReadValid = (r_readOwner == OWN_HOST) & i_reset;
    assign o_hostReadData  = i_memReadData;
    assign o_cpuReadData   = i_memReadData;

    logic [WORD_W-1:0] w_unusedWidthCheck;
    assign w_unusedWidthCheck = i_memReadData;

endmodule
